// File: rtl/vga_sprite_mover.sv
// ============================================================================
// vga_sprite_mover : button-driven square sprite overlaid on the palette pixel
// stream, with frame-aligned position commit. Optional macro: SPRITE_BORDER_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_sprite_mover #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          SIZE       = 40,
  parameter int          STEP       = 1,
  parameter int          TICK_DIV   = 20000,
  parameter int          WRAP       = 0,
  parameter logic [23:0] SPRITE_BGR = 24'hff0000,
  parameter int          X_INIT     = 0,
  parameter int          Y_INIT     = 0
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        iVS,
  input  logic [9:0]  iCUR_X,
  input  logic [9:0]  iCUR_Y,
  input  logic [23:0] iBGR,
  input  logic        iRIGHT_n,
  input  logic        iLEFT_n,
  input  logic        iDOWN_n,
  input  logic        iUP_n,
  output logic [23:0] oBGR,
  output logic [9:0]  oSPR_X,
  output logic [9:0]  oSPR_Y,
  output logic        oTICK
);

  localparam int                 CNT_W      = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic signed [10:0] C_X_MAX    = 11'(H_ACTIVE - SIZE);
  localparam logic signed [10:0] C_Y_MAX    = 11'(V_ACTIVE - SIZE);
  localparam logic signed [10:0] C_STEP     = 11'(STEP);
  localparam logic [10:0]        C_SIZE     = 11'(SIZE);
  localparam logic [9:0]         C_X_INIT   = 10'(X_INIT);
  localparam logic [9:0]         C_Y_INIT   = 10'(Y_INIT);

  // Button vectors are ordered {right, left, down, up}.
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic             vs_q, vs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [9:0]       pend_x_q, pend_x_d;
  logic [9:0]       pend_y_q, pend_y_d;
  logic [9:0]       spr_x_q, spr_x_d;
  logic [9:0]       spr_y_q, spr_y_d;
  logic [23:0]      bgr_q, bgr_d;

  logic [3:0]       pressed;
  logic [10:0]      cur_x, cur_y, spr_x, spr_y;
  logic             in_sprite;
`ifdef SPRITE_BORDER_EN
  logic             on_border;
`endif

  // One movement step on one axis; signed 11-bit keeps underflow visible.
  function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic inc,
                                           input logic dec, input logic signed [10:0] max);
    logic signed [10:0] v;
    v = $signed({1'b0, pos});
    if (inc && !dec)
      v = v + C_STEP;
    else if (dec && !inc)
      v = v - C_STEP;
    if (WRAP != 0) begin
      if (v > max)
        v = v - (max + 11'sd1);
      else if (v < 11'sd0)
        v = v + (max + 11'sd1);
    end else begin
      if (v > max)
        v = max;
      else if (v < 11'sd0)
        v = 11'sd0;
    end
    return v[9:0];
  endfunction

  always_comb begin
    sync1_d  = {iRIGHT_n, iLEFT_n, iDOWN_n, iUP_n};
    sync2_d  = sync1_q;
    vs_d     = iVS;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    spr_x_d  = spr_x_q;
    spr_y_d  = spr_y_q;
    pressed  = ~sync2_q;

    cnt_d  = (cnt_q == C_CNT_LAST) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_d == C_CNT_LAST);

    if (tick_q) begin
      pend_x_d = step_axis(pend_x_q, pressed[3], pressed[2], C_X_MAX);
      pend_y_d = step_axis(pend_y_q, pressed[1], pressed[0], C_Y_MAX);
    end

    // Commit samples the pre-tick pending value if both land together.
    if (vs_q && !iVS) begin
      spr_x_d = pend_x_q;
      spr_y_d = pend_y_q;
    end

    cur_x = {1'b0, iCUR_X};
    cur_y = {1'b0, iCUR_Y};
    spr_x = {1'b0, spr_x_q};
    spr_y = {1'b0, spr_y_q};
    in_sprite = (cur_x >= spr_x) && (cur_x < spr_x + C_SIZE) &&
                (cur_y >= spr_y) && (cur_y < spr_y + C_SIZE);

`ifdef SPRITE_BORDER_EN
    on_border = (cur_x == spr_x) || (cur_x == spr_x + C_SIZE - 11'd1) ||
                (cur_y == spr_y) || (cur_y == spr_y + C_SIZE - 11'd1);
    bgr_d = in_sprite ? (on_border ? ~SPRITE_BGR : SPRITE_BGR) : iBGR;
`else
    bgr_d = in_sprite ? SPRITE_BGR : iBGR;
`endif
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1_q  <= 4'hf;
      sync2_q  <= 4'hf;
      vs_q     <= 1'b1;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      pend_x_q <= C_X_INIT;
      pend_y_q <= C_Y_INIT;
      spr_x_q  <= C_X_INIT;
      spr_y_q  <= C_Y_INIT;
      bgr_q    <= 24'h0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      vs_q     <= vs_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      spr_x_q  <= spr_x_d;
      spr_y_q  <= spr_y_d;
      bgr_q    <= bgr_d;
    end
  end

  assign oBGR   = bgr_q;
  assign oSPR_X = spr_x_q;
  assign oSPR_Y = spr_y_q;
  assign oTICK  = tick_q;

endmodule

`default_nettype wire
